// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: services one access
// LATENCY cycles after acceptance, holding busy meanwhile, then pulses done.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int AW = DEPTH_LOG2 + 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_accept;
    logic               w_commit;

    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sign;
    logic [AW-1:0]      r_addr;
    logic [31:0]        r_wdata;

    logic               r_done;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [31:0]        r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic [31:0]        w_wdat;
    logic [3:0]         w_be;
    logic               w_err;
    logic               w_unused;

    // Upper address bits only alias the array.
    assign w_unused = ^i_addr[31:AW];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = i_req & ~r_done;
                if (i_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 4'(LATENCY - 1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request fields are captured once; pipeline changes during WAIT are ignored.
    always_ff @(posedge i_clk) begin
        if (w_accept && !i_rst) begin
            r_we    <= i_we;
            r_size  <= i_size;
            r_sign  <= i_sign;
            r_addr  <= i_addr[AW-1:0];
            r_wdata <= i_wdata;
        end
    end

    assign w_idx  = r_addr[AW-1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_err  = 1'b0;
        w_load = w_word;
        w_wdat = r_wdata;
        w_be   = 4'b1111;
        case (r_size)
            2'b00: begin
                w_load = {{24{r_sign & w_byte[7]}}, w_byte};
                w_wdat = {4{r_wdata[7:0]}};
                w_be   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_err  = r_addr[0];
                w_load = {{16{r_sign & w_half[15]}}, w_half};
                w_wdat = {2{r_wdata[15:0]}};
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_err = (r_addr[1:0] != 2'b00);
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_commit && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done  <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
            end
        end
    end

    assign o_done  = r_done;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (LATENCY 1,2,4,5) driven by directed
// and random accesses, checked against a word-array model with arithmetic lane handling.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_s   [4];
    logic        we_s    [4];
    logic [1:0]  size_s  [4];
    logic        sign_s  [4];
    logic [31:0] addr_s  [4];
    logic [31:0] wdata_s [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic [31:0] rdata_s [4];
    logic        err_s   [4];

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mdl [4][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
            dmem_responder #(.DEPTH_LOG2(10), .LATENCY(L)) u_dut (
                .i_clk   (clk),
                .i_rst   (rst),
                .i_req   (req_s[g]),
                .i_we    (we_s[g]),
                .i_size  (size_s[g]),
                .i_sign  (sign_s[g]),
                .i_addr  (addr_s[g]),
                .i_wdata (wdata_s[g]),
                .o_busy  (busy_s[g]),
                .o_done  (done_s[g]),
                .o_rdata (rdata_s[g]),
                .o_err   (err_s[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Reference: whole-word array, lanes picked with shifts and masks.
    task automatic model(input int k, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_er);
        int unsigned idx, off;
        logic [31:0] w, mask, v;
        idx    = (a / 4) % 1024;
        off    = a % 4;
        w      = mdl[k][idx];
        exp_er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) == 1) || (sz == 2'd2 && off != 0);
        exp_rd = 32'd0;
        if (!exp_er) begin
            if (we) begin
                if (sz == 2'd0) begin
                    mask = 32'hFF << (8 * off);
                    mdl[k][idx] = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
                end else if (sz == 2'd1) begin
                    mask = 32'hFFFF << (8 * off);
                    mdl[k][idx] = (w & ~mask) | ((wd & 32'hFFFF) << (8 * off));
                end else begin
                    mdl[k][idx] = wd;
                end
            end else begin
                if (sz == 2'd0) begin
                    v = (w >> (8 * off)) & 32'hFF;
                    if (sg && v >= 128) v = v + 32'hFFFFFF00;
                end else if (sz == 2'd1) begin
                    v = (w >> (8 * off)) & 32'hFFFF;
                    if (sg && v >= 32768) v = v + 32'hFFFF0000;
                end else begin
                    v = w;
                end
                exp_rd = v;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic access(input int k, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input bit keep,
                          output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        model(k, we, sz, sg, a, wd, exp_rd, exp_er);
        we_s[k] = we; size_s[k] = sz; sign_s[k] = sg; addr_s[k] = a; wdata_s[k] = wd;
        req_s[k] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < lat_of(k); i++) begin
            @(negedge clk);
            chk("wait_busy_done", {30'd0, busy_s[k], done_s[k]}, 32'd2);
            addr_s[k] = $urandom; wdata_s[k] = $urandom;
            we_s[k] = 1'($urandom); size_s[k] = 2'($urandom); sign_s[k] = 1'($urandom);
        end
        @(negedge clk);
        chk("done_busy_done", {30'd0, busy_s[k], done_s[k]}, 32'd1);
        chk("rdata", rdata_s[k], exp_rd);
        chk("err", {31'd0, err_s[k]}, {31'd0, exp_er});
        rd = rdata_s[k];
        er = err_s[k];
        if (!keep) req_s[k] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        seen;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; size_s[k] = 2'd0; sign_s[k] = 1'b0;
            addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_outs", {29'd0, busy_s[k], done_s[k], err_s[k]}, 32'd0);
            chk("rst_rdata", rdata_s[k], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Word round trip, byte lanes, misalignment, aliasing on LATENCY=2.
        access(1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rd, er);
        @(negedge clk);
        access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);  chk("rt_lw", rd, 32'hDEADBEEF);
        @(negedge clk);
        access(1, 1, 2'd0, 0, 32'h13, 32'h5A, 0, rd, er);
        access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);  chk("sb_lw", rd, 32'h5AADBEEF);
        access(1, 0, 2'd0, 1, 32'h12, 32'h0, 0, rd, er);  chk("lb", rd, 32'hFFFFFFAD);
        access(1, 0, 2'd0, 0, 32'h12, 32'h0, 0, rd, er);  chk("lbu", rd, 32'h000000AD);
        access(1, 0, 2'd1, 1, 32'h10, 32'h0, 0, rd, er);  chk("lh", rd, 32'hFFFFBEEF);
        access(1, 0, 2'd1, 0, 32'h12, 32'h0, 0, rd, er);  chk("lhu", rd, 32'h00005AAD);
        access(1, 0, 2'd2, 0, 32'h11, 32'h0, 0, rd, er);  chk("mis_lw", {31'd0, er}, 32'd1);
        access(1, 1, 2'd1, 0, 32'h13, 32'hFFFF, 0, rd, er); chk("mis_sh", {31'd0, er}, 32'd1);
        access(1, 0, 2'd3, 0, 32'h10, 32'h0, 0, rd, er);  chk("rsv_size", {31'd0, er}, 32'd1);
        access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);  chk("post_mis", rd, 32'h5AADBEEF);
        access(1, 1, 2'd2, 0, 32'h1010, 32'hCAFEF00D, 0, rd, er);
        access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, rd, er);  chk("alias", rd, 32'hCAFEF00D);

        // Four back-to-back accesses with req held, LATENCY 1 and 5.
        for (int k = 0; k < 4; k += 3) begin
            @(negedge clk);
            access(k, 1, 2'd2, 0, 32'h40, 32'hA5A5_0001 + k, 1, rd, er);
            access(k, 0, 2'd2, 0, 32'h40, 32'h0, 1, rd, er);
            access(k, 1, 2'd1, 0, 32'h42, 32'h0000_7777, 1, rd, er);
            access(k, 0, 2'd2, 0, 32'h40, 32'h0, 0, rd, er);
            @(negedge clk);
            chk("b2b_no_dup", {31'd0, done_s[k]}, 32'd0);
        end

        // Reset in the 2nd WAIT cycle of a LATENCY=4 store.
        @(negedge clk);
        access(2, 1, 2'd2, 0, 32'h20, 32'h11112222, 0, rd, er);
        @(negedge clk);
        we_s[2] = 1'b1; size_s[2] = 2'd2; addr_s[2] = 32'h20; wdata_s[2] = 32'h12345678;
        req_s[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_s[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy_done", {30'd0, busy_s[2], done_s[2]}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | done_s[2] | busy_s[2];
        end
        chk("rst_mid_quiet", {31'd0, seen}, 32'd0);
        access(2, 0, 2'd2, 0, 32'h20, 32'h0, 0, rd, er);  chk("rst_no_commit", rd, 32'h11112222);

        // Randomized accesses over a pre-written region with aliased upper bits.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int w = 0; w < 16; w++)
                access(k, 1, 2'd2, 0, 32'(w * 4), $urandom, 0, rd, er);
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
                access(k, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                       (n != 39) && ($urandom_range(0, 1) == 1), rd, er);
                if (!req_s[k] && $urandom_range(0, 2) == 0) @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's MEM-stage load/store interface.
- The pipeline presents address, store data, size and write-enable; this block services the access after a configurable latency.
- Holds `busy` high so the hazard unit can stall the pipeline, then pulses `done` with read data or an alignment error.
- Backing store is an internal word array with byte-lane writes and sign/zero-extended sub-word reads.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array (default 1024 words = 4 KB).
- LATENCY, 2, cycles from request acceptance to `done`; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  1  access request; held with stable fields until `done`.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (flagged as an error).
- sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- busy  output  1  stall request to the pipeline.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  load result, valid while `done`=1.
- err  output  1  misaligned or reserved-size access, valid while `done`=1.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, counter=0, done=0, rdata=0, err=0.
  - Array contents are not cleared.
  - An in-flight access is abandoned; a pending store is never committed.
- States: IDLE, WAIT.
- IDLE with req=1:
  - Latch we, size, sign, addr, wdata.
  - Load counter with LATENCY-1.
  - Move to WAIT.
- WAIT with counter!=0: decrement counter.
- WAIT with counter=0:
  - On that edge, commit the store if one is pending and legal, register rdata/err, set done=1, return to IDLE.
- Resulting latency: acceptance in cycle T gives done=1 in cycle T+LATENCY; done is high for exactly one cycle.
- busy (combinational) = (state==IDLE & req & ~done) | (state==WAIT).
  - busy is low in the done cycle, so the pipeline advances.
- Back-to-back: a req present in the done cycle is a new access.
  - It is accepted on the next edge (done deasserts, state leaves IDLE).
  - busy rises in the following cycle.
- While in WAIT, changes on request inputs are ignored; the latched copy is used.
- Address map:
  - Word index = addr[DEPTH_LOG2+1:2]; upper bits are ignored, so addresses alias modulo 4·2^DEPTH_LOG2.
  - Byte lane: addr[1:0]=0 selects bits [7:0], up to addr[1:0]=3 selecting bits [31:24] (little-endian).
  - Halfword lane: addr[1] selects the half.
- Alignment errors (no array change, rdata=0, err=1 in the done cycle, same latency as a legal access):
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11.
- Stores: write only the addressed lanes; other bytes of the word are unchanged. err=0, rdata=0 on done.
- Loads:
  - Extract the lane.
  - Extend to 32 bits by `sign` (word loads ignore `sign`).
  - The read uses the array contents at the commit edge.
- A store followed by a load of the same word sees the stored data. There is no internal forwarding hazard, because accesses are serialized.

Test Plan:
- Word round trip: LATENCY=2, sw 0xDEADBEEF to 0x10, then lw 0x10 -> done exactly 2 cycles after each acceptance, busy high for 2 cycles each, rdata=0xDEADBEEF, err=0.
- Byte lanes: after the above, sb 0x5A to 0x13 -> word reads 0x5AADBEEF. lb 0x12 (sign=1) -> 0xFFFFFFAD. lbu 0x12 -> 0x000000AD. lh 0x10 (sign=1) -> 0xFFFFBEEF. lhu 0x12 -> 0x00005AAD.
- Misalignment: lw 0x11, sh 0x13, size=11 at 0x10 -> each done with err=1, rdata=0; subsequent lw 0x10 still returns 0x5AADBEEF.
- Back-to-back and latency sweep: LATENCY=1, then 5. Hold req high for four consecutive accesses -> done pulses exactly every LATENCY+1 cycles (latency after acceptance plus the acceptance edge), no dropped or duplicated done.
- Reset mid-operation: LATENCY=4, sw 0x12345678 to 0x20, assert rst in the 2nd WAIT cycle -> done never pulses, busy=0 after reset; lw 0x20 returns the prior contents (not 0x12345678).
- Aliasing: DEPTH_LOG2=10, sw 0xCAFEF00D to 0x1010 -> lw 0x10 returns 0xCAFEF00D.
